poly_byte_encoder: RTL and testbench
====================================

// Module: poly_byte_encoder
// PURPOSE
//  Reads one 256-coefficient polynomial from the 96-bit coefficient RAM (8 x 12-bit coeffs/word, 32 words)
//  and serialises it as the 384-byte ByteEncode_12 stream in natural coefficient order (a0,a1,...,a255).
//  Read-side counterpart of the matrix-A parse/write path; feeds public-key/ciphertext byte output.
// PARAMETERS
//  KYBER_Q    3329  modulus used by the optional reduction
//  N_WORDS    32    RAM words per polynomial
//  N_PASS     4     read passes per polynomial (one per 64-coefficient quarter)
// PORTS
//  clk                input   1   system clock, rising edge
//  rst                input   1   asynchronous reset, active-high
//  active             input   1   start pulse; sampled only in IDLE
//  ram_r_start_offset input   8   base RAM address of the polynomial; latched on start
//  ren                output  1   RAM read enable
//  raddr              output  8   RAM read address
//  din                input   96  RAM read data, valid exactly 1 cycle after ren
//  out_byte           output  8   encoded byte
//  out_valid          output  1   out_byte valid
//  out_ready          input   1   downstream accepts byte when out_valid & out_ready
//  busy               output  1   high from the cycle after start until done
//  done               output  1   one-cycle pulse after the 384th byte is accepted
// BEHAVIOUR
//  Reset: all outputs 0; FSM -> IDLE; pass, word and byte counters cleared. Reset mid-run aborts silently (no done).
//  RAM word k layout: [0+:12]=a[2k], [12+:12]=a[2k+1], [24+:12]=a[128+2k], [36+:12]=a[129+2k],
//   [48+:12]=a[64+2k], [60+:12]=a[65+2k], [72+:12]=a[192+2k], [84+:12]=a[193+2k].
//  Pass slot-pair select: pass0 bits[0+:24], pass1 [48+:24], pass2 [24+:24], pass3 [72+:24].
//  FSM states:
//   IDLE : active=1 -> latch offset, pass=0, word=0 -> READ. active while not IDLE is ignored.
//   READ : ren=1, raddr=offset+word (8-bit, wraps mod 256) for exactly one cycle -> WAIT.
//   WAIT : capture din slot pair (x=even, y=odd coeff) into holding reg -> EMIT, byte idx=0.
//   EMIT : out_valid=1; out_byte = idx0: x[7:0]; idx1: {y[3:0],x[11:8]}; idx2: y[11:4].
//          Advance idx only on out_valid&out_ready; out_byte stable while stalled.
//          After idx2 accepted: word==31 -> word=0, pass+1; pass==3 & word==31 -> DONE; else -> READ.
//   DONE : done=1 one cycle, busy=0 -> IDLE.
//  Latency: start->first ren 1 cycle; ren->first out_valid 2 cycles; best case 3 bytes / 5 cycles, 640 cycles total.
//  Exactly 128 RAM reads and 384 byte handshakes per run; no read issued while EMIT is stalled.
//  out_ready held low indefinitely: block waits in EMIT, no data lost or duplicated.
//  busy=1 in READ/WAIT/EMIT; ren only asserted in READ.
// CONFIGURATION
//  Macro PBE_COEF_REDUCE_EN:
//   defined   : each captured 12-bit coeff c >= KYBER_Q is replaced by c-KYBER_Q before packing (canonical output).
//   undefined : coefficients packed raw; caller guarantees c < KYBER_Q. No other behaviour differs.
// STRUCTURE
//  kyber_pkg: KYBER_Q, N_WORDS, N_PASS, slot-offset constants per pass, FSM state enum (IDLE/READ/WAIT/EMIT/DONE).
//  Sub-module coef_pair_packer: combinational {x,y,idx} -> out_byte (incl. optional reduction); rest in top.
// TESTING
//  T1 RAM preloaded with a[i]=i, offset=0, out_ready=1 -> bytes 00,10,00,02,30,00,... ; 384 bytes; done once at cycle 640.
//  T2 offset=8'hF0 -> raddr sequence F0..FF,00..0F each pass (wrap), stream identical to T1.
//  T3 random out_ready (50%) with a[i]=random<3329 -> stream equals golden ByteEncode_12; out_byte stable while stalled.
//  T4 a[5]=12'hFFF: with PBE_COEF_REDUCE_EN byte pair encodes 12'h2FE (767... 4095-3329=766=12'h2FE); without, 12'hFFF raw.
//  T5 rst asserted at byte 200 -> all outputs 0 next edge, no done; new active runs full 384 bytes correctly.
//  T6 active pulsed repeatedly while busy -> ignored; exactly 128 ren pulses and one done.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared constants, FSM state type and helpers for the polynomial byte encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package kyber_pkg;

  localparam int KYBER_Q = 3329;
  localparam int N_WORDS = 32;
  localparam int N_PASS  = 4;
  localparam int COEF_W  = 12;
  localparam int WORD_W  = 96;

  // Bit offset of the even coefficient of the slot pair read in each pass.
  // The RAM interleaves quarters as q0,q2,q1,q3, so natural order needs 0,48,24,72.
  localparam logic [6:0] PASS0_LO = 7'd0;
  localparam logic [6:0] PASS1_LO = 7'd48;
  localparam logic [6:0] PASS2_LO = 7'd24;
  localparam logic [6:0] PASS3_LO = 7'd72;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_EMIT,
    ST_DONE
  } pbe_state_e;

  function automatic logic [6:0] pass_slot_lo(input logic [1:0] pass);
    logic [6:0] lo;
    case (pass)
      2'd0:    lo = PASS0_LO;
      2'd1:    lo = PASS1_LO;
      2'd2:    lo = PASS2_LO;
      default: lo = PASS3_LO;
    endcase
    return lo;
  endfunction

  // Single conditional subtraction: maps [Q, 4095] into [0, 4095-Q].
  function automatic logic [COEF_W-1:0] coef_reduce(input logic [COEF_W-1:0] c);
    return (c >= COEF_W'(KYBER_Q)) ? (c - COEF_W'(KYBER_Q)) : c;
  endfunction

endpackage

// File: rtl/poly_byte_encoder_coef_pair_packer.sv
// Packs two 12-bit coefficients into the three ByteEncode_12 bytes, selected by idx_i.
// Latency: purely combinational.
// Backpressure: none; the caller holds x/y/idx stable while the byte is stalled.
// Optional canonical reduction of each coefficient when PBE_COEF_REDUCE_EN is defined.
module coef_pair_packer
  import kyber_pkg::*;
(
  input  logic [COEF_W-1:0] x_i,
  input  logic [COEF_W-1:0] y_i,
  input  logic [1:0]        idx_i,
  output logic [7:0]        byte_o
);

  logic [COEF_W-1:0] xr;
  logic [COEF_W-1:0] yr;

`ifdef PBE_COEF_REDUCE_EN
  assign xr = coef_reduce(x_i);
  assign yr = coef_reduce(y_i);
`else
  assign xr = x_i;
  assign yr = y_i;
`endif

  // Byte select: low 8 of x, then y-low-nibble over x-high-nibble, then high 8 of y.
  always_comb begin
    byte_o = 8'h00;
    case (idx_i)
      2'd0:    byte_o = xr[7:0];
      2'd1:    byte_o = {yr[3:0], xr[11:8]};
      default: byte_o = yr[11:4];
    endcase
  end

endmodule

// File: rtl/poly_byte_encoder.sv
// Streams one 256-coefficient polynomial from the coefficient RAM as 384 ByteEncode_12 bytes.
// Latency: start->ren 1 cycle, ren->first byte 2 cycles; 5 cycles per 3 bytes, 640 cycles unstalled.
// Backpressure: valid/ready on out_byte; stalls hold the byte and issue no further RAM reads.
// Optional feature macro: PBE_COEF_REDUCE_EN (canonical reduction mod KYBER_Q before packing).
module poly_byte_encoder
  import kyber_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic [7:0]        ram_r_start_offset,
  output logic              ren,
  output logic [7:0]        raddr,
  input  logic [WORD_W-1:0] din,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [4:0] LAST_WORD = 5'(N_WORDS - 1);
  localparam logic [1:0] LAST_PASS = 2'(N_PASS - 1);

  pbe_state_e        state_q;
  logic [7:0]        offset_q;
  logic [4:0]        word_q;
  logic [1:0]        pass_q;
  logic [1:0]        idx_q;
  logic [COEF_W-1:0] x_q;
  logic [COEF_W-1:0] y_q;
  logic              ren_q;
  logic [7:0]        raddr_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              done_q;

  logic [4:0]        word_d;
  logic [7:0]        raddr_d;
  logic [6:0]        slot_lo;

  // Next word index wraps 31->0 naturally; address wraps mod 256 from the latched base.
  always_comb begin
    word_d  = word_q + 5'd1;
    raddr_d = offset_q + {3'b000, word_d};
    slot_lo = pass_slot_lo(pass_q);
  end

  // Control FSM with all externally visible strobes registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      offset_q    <= 8'h00;
      word_q      <= 5'd0;
      pass_q      <= 2'd0;
      idx_q       <= 2'd0;
      x_q         <= '0;
      y_q         <= '0;
      ren_q       <= 1'b0;
      raddr_q     <= 8'h00;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (active) begin
            offset_q <= ram_r_start_offset;
            word_q   <= 5'd0;
            pass_q   <= 2'd0;
            ren_q    <= 1'b1;
            raddr_q  <= ram_r_start_offset;
            busy_q   <= 1'b1;
            state_q  <= ST_READ;
          end
        end
        ST_READ: begin
          ren_q   <= 1'b0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // RAM data is valid in this cycle; take the slot pair for the current quarter.
          x_q         <= din[slot_lo +: COEF_W];
          y_q         <= din[(slot_lo + 7'd12) +: COEF_W];
          idx_q       <= 2'd0;
          out_valid_q <= 1'b1;
          state_q     <= ST_EMIT;
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (idx_q == 2'd2) begin
              out_valid_q <= 1'b0;
              idx_q       <= 2'd0;
              word_q      <= word_d;
              if (word_q == LAST_WORD) begin
                pass_q <= pass_q + 2'd1;
              end
              if ((word_q == LAST_WORD) && (pass_q == LAST_PASS)) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end else begin
                ren_q   <= 1'b1;
                raddr_q <= raddr_d;
                state_q <= ST_READ;
              end
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  coef_pair_packer u_packer (
    .x_i    (x_q),
    .y_i    (y_q),
    .idx_i  (idx_q),
    .byte_o (out_byte)
  );

  assign ren       = ren_q;
  assign raddr     = raddr_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_poly_byte_encoder.sv
// Directed bench for poly_byte_encoder: RAM model, byte collector and golden ByteEncode_12 stream.
// Inputs driven #1 after the rising edge; outputs sampled on the falling edge.
module tb_poly_byte_encoder;

  logic        clk;
  logic        rst;
  logic        active;
  logic [7:0]  off_in;
  logic        ren;
  logic [7:0]  raddr;
  logic [95:0] din;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  poly_byte_encoder dut (
    .clk                (clk),
    .rst                (rst),
    .active             (active),
    .ram_r_start_offset (off_in),
    .ren                (ren),
    .raddr              (raddr),
    .din                (din),
    .out_byte           (out_byte),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .busy               (busy),
    .done               (done)
  );

  logic [95:0] mem   [256];
  logic [11:0] coef  [256];
  logic [7:0]  exp_b [384];

  int vecs;
  int errs;
  int ren_cnt, done_cnt, busy_cnt, stall_bad;
  logic [7:0] got[$];
  logic [7:0] raddr_log[$];
  int b_got, b_ren, b_done, b_busy, b_stall, b_raddr;
  bit rdy_rand;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: data one cycle after ren, junk otherwise.
  initial begin
    din = '0;
    forever begin
      @(posedge clk);
      if (ren) din <= mem[raddr];
      else     din <= {8{12'hBAD}};
    end
  end

  // Downstream ready: always 1, or a fair coin per cycle.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Collector: counts strobes, logs reads and accepted bytes, flags bytes changing under stall.
  initial begin
    logic       stall_prev;
    logic [7:0] stall_byte;
    stall_prev = 1'b0;
    stall_byte = 8'h00;
    ren_cnt = 0; done_cnt = 0; busy_cnt = 0; stall_bad = 0;
    forever begin
      @(negedge clk);
      if (ren) begin
        ren_cnt++;
        raddr_log.push_back(raddr);
      end
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (!rst && stall_prev && (out_valid !== 1'b1 || out_byte !== stall_byte)) stall_bad++;
      stall_prev = !rst && out_valid && !out_ready;
      stall_byte = out_byte;
      if (out_valid && out_ready) got.push_back(out_byte);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vecs++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [11:0] red12(input logic [11:0] c);
`ifdef PBE_COEF_REDUCE_EN
    return (c >= 12'd3329) ? c - 12'd3329 : c;
`else
    return c;
`endif
  endfunction

  // Golden ByteEncode_12 over coef[] in natural order.
  task automatic build_exp();
    logic [11:0] x, y;
    for (int p = 0; p < 128; p++) begin
      x = red12(coef[2*p]);
      y = red12(coef[2*p+1]);
      exp_b[3*p]   = x[7:0];
      exp_b[3*p+1] = {y[3:0], x[11:8]};
      exp_b[3*p+2] = y[11:4];
    end
  endtask

  // Scatter coef[] into the interleaved RAM word layout at base offset.
  task automatic load_ram(input logic [7:0] off);
    logic [95:0] w;
    logic [7:0]  a;
    for (int i = 0; i < 256; i++) mem[i] = {3{32'hA5A5_5A5A}};
    for (int k = 0; k < 32; k++) begin
      w = '0;
      w[0  +: 12] = coef[2*k];
      w[12 +: 12] = coef[2*k+1];
      w[24 +: 12] = coef[128+2*k];
      w[36 +: 12] = coef[129+2*k];
      w[48 +: 12] = coef[64+2*k];
      w[60 +: 12] = coef[65+2*k];
      w[72 +: 12] = coef[192+2*k];
      w[84 +: 12] = coef[193+2*k];
      a = off + 8'(k);
      mem[a] = w;
    end
  endtask

  task automatic snapshot();
    b_got   = got.size();
    b_ren   = ren_cnt;
    b_done  = done_cnt;
    b_busy  = busy_cnt;
    b_stall = stall_bad;
    b_raddr = raddr_log.size();
  endtask

  task automatic start_poly(input logic [7:0] off);
    @(posedge clk);
    #1;
    off_in = off;
    active = 1'b1;
    @(posedge clk);
    #1;
    active = 1'b0;
  endtask

  task automatic wait_done(input string t, input bit spam, input int budget);
    bit seen;
    int n;
    seen = 0;
    n = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin
        @(posedge clk);
        #1;
        active = spam && (n % 9 == 4);
      end
      n++;
    end
    active = 1'b0;
    chk({t, " done_within_budget"}, 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_run(input string t, input logic [7:0] off, input bit chk_busy);
    logic [7:0] ea;
    chk({t, " byte_count"}, 32'(got.size() - b_got), 32'd384);
    for (int i = 0; i < 384; i++)
      if (b_got + i < got.size())
        chk($sformatf("%s byte%0d", t, i), 32'(got[b_got+i]), 32'(exp_b[i]));
    chk({t, " ren_pulses"}, 32'(ren_cnt - b_ren), 32'd128);
    chk({t, " done_pulses"}, 32'(done_cnt - b_done), 32'd1);
    chk({t, " stall_stable"}, 32'(stall_bad - b_stall), 32'd0);
    for (int k = 0; k < 128; k++)
      if (b_raddr + k < raddr_log.size()) begin
        ea = off + 8'(k % 32);
        chk($sformatf("%s raddr%0d", t, k), 32'(raddr_log[b_raddr+k]), 32'(ea));
      end
    if (chk_busy) chk({t, " busy_cycles"}, 32'(busy_cnt - b_busy), 32'd640);
  endtask

  initial begin
    int n;
    vecs = 0;
    errs = 0;
    rdy_rand = 0;
    rst = 1'b1;
    active = 1'b0;
    off_in = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst ren", 32'(ren), 32'd0);
    chk("rst raddr", 32'(raddr), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_byte", 32'(out_byte), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    rst = 1'b0;

    // T1: a[i]=i, offset 0, ready always high, plus start/first-byte latency.
    for (int i = 0; i < 256; i++) coef[i] = 12'(i);
    build_exp();
    chk("T1 golden b1", 32'(exp_b[1]), 32'h10);
    load_ram(8'h00);
    snapshot();
    start_poly(8'h00);
    @(negedge clk);
    chk("T1 ren_after_start", 32'(ren), 32'd1);
    chk("T1 busy_after_start", 32'(busy), 32'd1);
    chk("T1 first_raddr", 32'(raddr), 32'd0);
    @(negedge clk);
    chk("T1 ren_one_cycle", 32'(ren), 32'd0);
    chk("T1 no_valid_in_wait", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("T1 first_valid", 32'(out_valid), 32'd1);
    chk("T1 first_byte", 32'(out_byte), 32'h00);
    wait_done("T1", 0, 2000);
    check_run("T1", 8'h00, 1);
    chk("T1 idle_busy", 32'(busy), 32'd0);

    // T2: base offset F0, address wraps through FF->00.
    load_ram(8'hF0);
    snapshot();
    start_poly(8'hF0);
    wait_done("T2", 0, 2000);
    check_run("T2", 8'hF0, 1);

    // T3: random coefficients below Q, random ready.
    for (int i = 0; i < 256; i++) coef[i] = 12'($urandom_range(0, 3328));
    build_exp();
    load_ram(8'h40);
    rdy_rand = 1;
    snapshot();
    start_poly(8'h40);
    wait_done("T3", 0, 6000);
    rdy_rand = 0;
    check_run("T3", 8'h40, 0);

    // T4: a[5]=FFF, pair (a4,a5) lands in bytes 6..8.
    for (int i = 0; i < 256; i++) coef[i] = 12'(i);
    coef[5] = 12'hFFF;
    build_exp();
    load_ram(8'h00);
    snapshot();
    start_poly(8'h00);
    wait_done("T4", 0, 2000);
    check_run("T4", 8'h00, 1);
    if (got.size() > b_got + 8) begin
      chk("T4 byte6", 32'(got[b_got+6]), 32'h04);
`ifdef PBE_COEF_REDUCE_EN
      chk("T4 byte7", 32'(got[b_got+7]), 32'hE0);
      chk("T4 byte8", 32'(got[b_got+8]), 32'h2F);
`else
      chk("T4 byte7", 32'(got[b_got+7]), 32'hF0);
      chk("T4 byte8", 32'(got[b_got+8]), 32'hFF);
`endif
    end else begin
      chk("T4 bytes_present", 32'(got.size() - b_got), 32'd384);
    end

    // T5: reset at byte 200 aborts silently; next run is complete.
    coef[5] = 12'd5;
    build_exp();
    load_ram(8'h00);
    snapshot();
    start_poly(8'h00);
    n = 0;
    while ((got.size() - b_got) < 200 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("T5 reached_byte200", 32'(got.size() - b_got >= 200), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("T5 ren", 32'(ren), 32'd0);
    chk("T5 raddr", 32'(raddr), 32'd0);
    chk("T5 out_valid", 32'(out_valid), 32'd0);
    chk("T5 out_byte", 32'(out_byte), 32'd0);
    chk("T5 busy", 32'(busy), 32'd0);
    chk("T5 done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("T5 no_done_after_abort", 32'(done_cnt - b_done), 32'd0);
    chk("T5 idle_after_abort", 32'(busy), 32'd0);
    snapshot();
    start_poly(8'h00);
    wait_done("T5", 0, 2000);
    check_run("T5", 8'h00, 1);

    // T6: active pulsed repeatedly while busy.
    load_ram(8'h10);
    snapshot();
    start_poly(8'h10);
    wait_done("T6", 1, 2000);
    check_run("T6", 8'h10, 1);
    repeat (5) @(negedge clk);
    chk("T6 stays_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
